// File: rtl/scoreboard_display_mux.sv
// Time-multiplexes the tens/ones 7-segment patterns onto one shared segment bus
// with per-digit enables, optional leading-zero blanking and a blink mode.
module scoreboard_display_mux #(
  parameter int unsigned DEAD_CYCLES        = 1,
  parameter int unsigned HOLD_CYCLES        = 5,
  parameter int unsigned BLINK_HALF_PERIOD  = 250,
  parameter bit          BLANK_LEADING_ZERO = 1'b1,
  parameter logic [6:0]  SEG_ZERO           = 7'b0111111
) (
  input  logic       clk_1khz_i,
  input  logic       rst_i,
  input  logic [6:0] seg_tens_i,
  input  logic [6:0] seg_ones_i,
  input  logic       blink_i,
  output logic [6:0] seg_o,
  output logic [1:0] dig_en_o
);

  localparam int unsigned SLOT_MAX = (DEAD_CYCLES > HOLD_CYCLES) ? DEAD_CYCLES : HOLD_CYCLES;
  localparam int unsigned SW       = $clog2(SLOT_MAX + 1);
  localparam int unsigned BW       = $clog2(BLINK_HALF_PERIOD + 1);

  typedef enum logic [1:0] {
    S_DEAD_T = 2'd0,
    S_TENS   = 2'd1,
    S_DEAD_O = 2'd2,
    S_ONES   = 2'd3
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_slot;
  logic [6:0]      r_tens_q;
  logic [6:0]      r_ones_q;
  logic [BW-1:0]   r_blink_cnt;
  logic            r_blink_off;

  state_t          w_state_nxt;
  logic            w_slot_last;
  logic            w_capture;
  logic [6:0]      w_tens_nxt;
  logic [6:0]      w_ones_nxt;
  logic [BW-1:0]   w_blink_cnt_nxt;
  logic            w_blink_off_nxt;

  // Bus contents {dig_en, seg} a state shows; the OFF blink phase darkens everything.
  function automatic logic [8:0] slot_view(
    input state_t     st,
    input logic [6:0] tens,
    input logic [6:0] ones,
    input logic       off
  );
    logic [8:0] view;
    case (st)
      S_TENS: begin
        if ((BLANK_LEADING_ZERO == 1'b1) && (tens == SEG_ZERO)) begin
          view = 9'd0;
        end else begin
          view = {2'b10, tens};
        end
      end
      S_ONES:  view = {2'b01, ones};
      S_DEAD_T: view = 9'd0;
      S_DEAD_O: view = 9'd0;
      default: view = 9'd0;
    endcase
    if (off) begin
      view = 9'd0;
    end
    return view;
  endfunction

  // Slot end detection: dead slots and digit slots have separate lengths.
  always_comb begin
    if ((r_state == S_DEAD_T) || (r_state == S_DEAD_O)) begin
      w_slot_last = (r_slot == SW'(DEAD_CYCLES - 1));
    end else begin
      w_slot_last = (r_slot == SW'(HOLD_CYCLES - 1));
    end
  end

  // Next state and frame capture; both digits are latched together when leaving S_DEAD_T.
  always_comb begin
    w_state_nxt = r_state;
    if (w_slot_last) begin
      case (r_state)
        S_DEAD_T: w_state_nxt = S_TENS;
        S_TENS:   w_state_nxt = S_DEAD_O;
        S_DEAD_O: w_state_nxt = S_ONES;
        S_ONES:   w_state_nxt = S_DEAD_T;
        default:  w_state_nxt = S_DEAD_T;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
    w_capture = w_slot_last && (r_state == S_DEAD_T);
    if (w_capture) begin
      w_tens_nxt = seg_tens_i;
      w_ones_nxt = seg_ones_i;
    end else begin
      w_tens_nxt = r_tens_q;
      w_ones_nxt = r_ones_q;
    end
  end

  // Blink phase: counter and phase are pinned to 0/ON whenever blink_i is low.
  always_comb begin
    if (!blink_i) begin
      w_blink_cnt_nxt = '0;
      w_blink_off_nxt = 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_HALF_PERIOD - 1)) begin
      w_blink_cnt_nxt = '0;
      w_blink_off_nxt = ~r_blink_off;
    end else begin
      w_blink_cnt_nxt = r_blink_cnt + BW'(1);
      w_blink_off_nxt = r_blink_off;
    end
  end

  // FSM registers; outputs come from the next state so they line up with it exactly.
  always_ff @(posedge clk_1khz_i) begin
    if (rst_i) begin
      r_state     <= S_DEAD_T;
      r_slot      <= '0;
      r_tens_q    <= 7'd0;
      r_ones_q    <= 7'd0;
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
      seg_o       <= 7'd0;
      dig_en_o    <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_tens_q    <= w_tens_nxt;
      r_ones_q    <= w_ones_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blink_off <= w_blink_off_nxt;
      if (w_slot_last) begin
        r_slot <= '0;
      end else begin
        r_slot <= r_slot + SW'(1);
      end
      {dig_en_o, seg_o} <= slot_view(w_state_nxt, w_tens_nxt, w_ones_nxt, w_blink_off_nxt);
    end
  end

endmodule

// File: tb/tb_scoreboard_display_mux.sv
// Randomised bench for scoreboard_display_mux: three parameterisations share one stimulus
// and are compared every cycle against a frame-position model, plus literal spot checks.
module tb_scoreboard_display_mux;

  localparam int          NI         = 3;
  localparam int          P_DEAD [NI] = '{1, 1, 2};
  localparam int          P_HOLD [NI] = '{5, 5, 3};
  localparam int          P_HALF [NI] = '{250, 250, 7};
  localparam bit          P_BLZ  [NI] = '{1'b1, 1'b0, 1'b1};
  localparam logic [6:0]  ZERO       = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
  logic       blink;
  logic [6:0] seg_o [NI];
  logic [1:0] dig_o [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scoreboard_display_mux #(.DEAD_CYCLES(1), .HOLD_CYCLES(5), .BLINK_HALF_PERIOD(250),
                           .BLANK_LEADING_ZERO(1'b1), .SEG_ZERO(7'b0111111)) u0 (
    .clk_1khz_i(clk), .rst_i(rst), .seg_tens_i(seg_tens), .seg_ones_i(seg_ones),
    .blink_i(blink), .seg_o(seg_o[0]), .dig_en_o(dig_o[0]));

  scoreboard_display_mux #(.DEAD_CYCLES(1), .HOLD_CYCLES(5), .BLINK_HALF_PERIOD(250),
                           .BLANK_LEADING_ZERO(1'b0), .SEG_ZERO(7'b0111111)) u1 (
    .clk_1khz_i(clk), .rst_i(rst), .seg_tens_i(seg_tens), .seg_ones_i(seg_ones),
    .blink_i(blink), .seg_o(seg_o[1]), .dig_en_o(dig_o[1]));

  scoreboard_display_mux #(.DEAD_CYCLES(2), .HOLD_CYCLES(3), .BLINK_HALF_PERIOD(7),
                           .BLANK_LEADING_ZERO(1'b1), .SEG_ZERO(7'b0111111)) u2 (
    .clk_1khz_i(clk), .rst_i(rst), .seg_tens_i(seg_tens), .seg_ones_i(seg_ones),
    .blink_i(blink), .seg_o(seg_o[2]), .dig_en_o(dig_o[2]));

  // Model: position in frame = edges since reset mod frame length; blink phase
  // = parity of (consecutive blink edges / half period).
  int         mdl_n   [NI];
  int         mdl_m   [NI];
  logic [6:0] mdl_tq  [NI];
  logic [6:0] mdl_oq  [NI];
  logic [6:0] exp_seg [NI];
  logic [1:0] exp_dig [NI];
  bit         model_valid = 1'b0;
  int         mdl_pos;
  int         mdl_frame;
  bit         mdl_off;

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        mdl_n[k] = 0; mdl_m[k] = 0; mdl_tq[k] = 7'd0; mdl_oq[k] = 7'd0;
        exp_seg[k] = 7'd0; exp_dig[k] = 2'b00;
      end else begin
        mdl_n[k] = mdl_n[k] + 1;
        mdl_m[k] = blink ? mdl_m[k] + 1 : 0;
        mdl_frame = 2 * (P_DEAD[k] + P_HOLD[k]);
        mdl_pos = mdl_n[k] % mdl_frame;
        if (mdl_pos == P_DEAD[k]) begin
          mdl_tq[k] = seg_tens;
          mdl_oq[k] = seg_ones;
        end
        mdl_off = ((mdl_m[k] / P_HALF[k]) % 2) == 1;
        exp_seg[k] = 7'd0;
        exp_dig[k] = 2'b00;
        if (!mdl_off) begin
          if (mdl_pos >= P_DEAD[k] && mdl_pos < P_DEAD[k] + P_HOLD[k]) begin
            if (!(P_BLZ[k] && mdl_tq[k] == ZERO)) begin
              exp_seg[k] = mdl_tq[k];
              exp_dig[k] = 2'b10;
            end
          end else if (mdl_pos >= 2 * P_DEAD[k] + P_HOLD[k]) begin
            exp_seg[k] = mdl_oq[k];
            exp_dig[k] = 2'b01;
          end
        end
      end
    end
    if (rst) model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (seg_o[k] !== exp_seg[k] || dig_o[k] !== exp_dig[k]) begin
          errors++;
          $display("FAIL model_cmp u%0d t=%0t: got seg=%b dig=%b, want seg=%b dig=%b",
                   k, $time, seg_o[k], dig_o[k], exp_seg[k], exp_dig[k]);
        end
        checks++;
        if (dig_o[k] === 2'b11 || (dig_o[k] === 2'b00 && seg_o[k] !== 7'd0)) begin
          errors++;
          $display("FAIL exclusion u%0d t=%0t: got seg=%b dig=%b, want dig!=11 and seg=0 when dig=00",
                   k, $time, seg_o[k], dig_o[k]);
        end
      end
    end
  end

  task automatic lit(input string nm, input int k, input logic [6:0] s, input logic [1:0] d);
    checks++;
    if (seg_o[k] !== s || dig_o[k] !== d) begin
      errors++;
      $display("FAIL %s u%0d: got seg=%b dig=%b, want seg=%b dig=%b", nm, k, seg_o[k], dig_o[k], s, d);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int blink_left;

  initial begin
    rst = 1'b1; blink = 1'b0;
    seg_tens = 7'b0000110; seg_ones = 7'b1011011;
    tick(3);
    lit("reset", 0, 7'd0, 2'b00);
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      if (e <= 5)                lit("frame_tens", 0, 7'b0000110, 2'b10);
      else if (e == 6 || e == 12) lit("frame_dead", 0, 7'd0, 2'b00);
      else                       lit("frame_ones", 0, 7'b1011011, 2'b01);
    end
    // tearing: change ones at edge 3 of the frame starting at edge 12
    tick(3);
    seg_ones = 7'b1001111;
    tick(4);
    lit("tear_hold", 0, 7'b1011011, 2'b01);
    tick(12);
    lit("tear_next", 0, 7'b1001111, 2'b01);
    // leading zero, blanking on (u0) and off (u1)
    seg_tens = ZERO; seg_ones = 7'b1101101;
    tick(6);
    lit("lz_blank", 0, 7'd0, 2'b00);
    lit("lz_show", 1, ZERO, 2'b10);
    tick(6);
    lit("lz_ones", 0, 7'b1101101, 2'b01);
    lit("lz_ones", 1, 7'b1101101, 2'b01);
    // blink from edge 44 onward
    seg_tens = 7'b0000110; seg_ones = 7'b1011011;
    blink = 1'b1;
    tick(249);
    lit("blink_on_last", 0, 7'b0000110, 2'b10);
    tick(3);
    lit("blink_off", 0, 7'd0, 2'b00);
    tick(105);
    lit("blink_off_late", 0, 7'd0, 2'b00);
    blink = 1'b0;
    tick(1);
    lit("blink_release", 0, 7'b0000110, 2'b10);
    // mid-frame reset during the ones slot
    tick(2);
    lit("pre_rst_ones", 0, 7'b1011011, 2'b01);
    rst = 1'b1;
    tick(1);
    lit("midrst", 0, 7'd0, 2'b00);
    rst = 1'b0;
    tick(1);
    lit("restart_tens", 0, 7'b0000110, 2'b10);
    tick(6);
    lit("restart_ones", 0, 7'b1011011, 2'b01);
    // randomised run
    blink_left = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 9) == 0)
        seg_tens = ($urandom_range(0, 3) == 0) ? ZERO : 7'($urandom);
      if ($urandom_range(0, 9) == 0)
        seg_ones = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom);
      if (blink_left == 0) begin
        blink = ~blink;
        blink_left = $urandom_range(20, 700);
      end else begin
        blink_left--;
      end
      rst = ($urandom_range(0, 799) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
